// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU program-load path.
// Holds the loader state encoding, the error codes and the instruction opcodes.
// Pure declarations; no logic or timing of its own.
package cpu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } loader_state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_CSUM  = 2'd2;
    localparam logic [1:0] ERR_ABORT = 2'd3;

    // Instruction opcodes carried in bits [7:4] of each program byte
    localparam logic [3:0] LDA = 4'b1000;
    localparam logic [3:0] LDB = 4'b0100;
    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] JMP = 4'b1001;
    localparam logic [3:0] HLT = 4'b1111;

endpackage

// File: rtl/loader_checksum.sv
// Running modulo-2**DATA_W sum of the accepted program bytes.
// Latency: sum reflects a byte the cycle after en; clear wins over en.
// Backpressure: none; the caller gates en with its own handshake.
module loader_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] sum
);

    // Accumulate, wrapping naturally at the register width
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a LEN/data/CSUM framed byte stream into program RAM and releases the CPU.
// Latency: each data byte is written the cycle after acceptance; done rises the cycle after CSUM.
// Backpressure: in_ready only in LEN/DATA/CSUM and dropped while abort is high; stalls wait forever.
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int              DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE    = (ADDR_W+1)'(1);

    loader_state_t     state, state_nx;
    logic [1:0]        err_code_nx;
    logic [ADDR_W:0]   len_q;      // frame length, 1..DEPTH
    logic [ADDR_W:0]   cnt_q;      // data bytes accepted so far
    logic [DATA_W-1:0] sum;
    logic              xfer;
    logic              restart;
    logic              len_bad;
    logic              last_byte;

    assign busy      = (state == LEN) || (state == DATA) || (state == CSUM);
    assign in_ready  = busy && !abort;
    assign xfer      = in_valid && in_ready;
    assign done      = (state == DONE);
    assign err       = (state == ERR);
    assign cpu_hold  = (state != DONE);
    assign restart   = start && !busy;
    assign len_bad   = (in_data == '0) || (32'(in_data) > DEPTH);
    assign last_byte = ((cnt_q + ONE) == len_q);

    loader_checksum #(.DATA_W(DATA_W)) u_checksum (
        .clk   (clk),
        .reset (reset),
        .clear (restart),
        .en    (xfer && (state == DATA)),
        .data  (in_data),
        .sum   (sum)
    );

    // State and error-code registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            err_code <= ERR_NONE;
        end else begin
            state    <= state_nx;
            err_code <= err_code_nx;
        end
    end

    // Next-state decode; abort outranks any byte presented in the same cycle
    always_comb begin
        state_nx    = state;
        err_code_nx = err_code;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nx    = LEN;
                    err_code_nx = ERR_NONE;
                end
            end
            LEN: begin
                if (abort) begin
                    state_nx    = ERR;
                    err_code_nx = ERR_ABORT;
                end else if (xfer) begin
                    if (len_bad) begin
                        state_nx    = ERR;
                        err_code_nx = ERR_LEN;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (abort) begin
                    state_nx    = ERR;
                    err_code_nx = ERR_ABORT;
                end else if (xfer && last_byte) begin
                    state_nx = CSUM;
                end
            end
            CSUM: begin
                if (abort) begin
                    state_nx    = ERR;
                    err_code_nx = ERR_ABORT;
                end else if (xfer) begin
                    if (in_data == sum) begin
                        state_nx = DONE;
                    end else begin
                        state_nx    = ERR;
                        err_code_nx = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Length latch, byte counter and registered RAM write port
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= '0;
            cnt_q     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_A;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                cnt_q <= '0;
            end
            if ((state == LEN) && xfer) begin
                len_q <= in_data[ADDR_W:0];
            end
            if ((state == DATA) && xfer) begin
                mem_we    <= 1'b1;
                mem_wdata <= in_data;
                mem_addr  <= BASE_A + cnt_q[ADDR_W-1:0];
                cnt_q     <= cnt_q + ONE;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: two loaders (base 0 and base 12) share one input stream.
// Frames are driven with optional stalls; outcomes come from a frame-level model.
// RAM is modelled here from the write port of each instance.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset, start, abort, in_valid;
    logic [7:0] in_data;

    logic       rdy0, we0, hold0, busy0, done0, err0;
    logic [3:0] addr0;
    logic [7:0] wd0;
    logic [1:0] code0;
    logic       rdy12, we12, hold12, busy12, done12, err12;
    logic [3:0] addr12;
    logic [7:0] wd12;
    logic [1:0] code12;

    program_loader #(.ADDR_W(4), .DATA_W(8), .BASE_ADDR(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
        .cpu_hold(hold0), .busy(busy0), .done(done0), .err(err0), .err_code(code0)
    );

    program_loader #(.ADDR_W(4), .DATA_W(8), .BASE_ADDR(12)) dut12 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy12),
        .mem_we(we12), .mem_addr(addr12), .mem_wdata(wd12),
        .cpu_hold(hold12), .busy(busy12), .done(done12), .err(err12), .err_code(code12)
    );

    always #5 clk = ~clk;

    // RAM behind each write port, plus write-pulse counters
    logic [7:0] ram0 [16];
    logic [7:0] ram12[16];
    int we_cnt0  = 0;
    int we_cnt12 = 0;
    always @(posedge clk) begin
        if (we0) begin
            ram0[addr0] <= wd0;
            we_cnt0     <= we_cnt0 + 1;
        end
        if (we12) begin
            ram12[addr12] <= wd12;
            we_cnt12      <= we_cnt12 + 1;
        end
    end

    // Reference model state
    logic [7:0] exp0 [16];
    logic [7:0] exp12[16];
    bit         wr0  [16];
    bit         wr12 [16];
    logic [7:0] pay[$];
    int         fr_len;
    logic [7:0] csum_b;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] pay_sum();
        int s = 0;
        foreach (pay[i]) s += int'(pay[i]);
        return 8'(s % 256);
    endfunction

    // The first k payload bytes land at base+i, wrapping in 16 entries
    task automatic model_write(input int k);
        for (int i = 0; i < k; i++) begin
            exp0[i % 16]         = pay[i];
            wr0[i % 16]          = 1'b1;
            exp12[(12 + i) % 16] = pay[i];
            wr12[(12 + i) % 16]  = 1'b1;
        end
    endtask

    // Whole-frame outcome from the framing rules
    task automatic model_frame(output bit e_done, output logic [1:0] e_code, output int e_writes);
        if (fr_len == 0 || fr_len > 16) begin
            e_done   = 1'b0;
            e_code   = 2'd1;
            e_writes = 0;
        end else begin
            model_write(fr_len);
            e_writes = fr_len;
            e_done   = (csum_b == pay_sum());
            e_code   = e_done ? 2'd0 : 2'd2;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int t;
        if (stall) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        t = 0;
        while (!rdy0 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!rdy0) begin
            n_checks++;
            $display("FAIL handshake_timeout: in_ready=%0b after %0d cycles, required 1", rdy0, t);
        end
        @(posedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Drive one frame; start_at >= 0 pulses start before that data byte
    task automatic send_frame(input bit stall, input int start_at);
        pulse_start();
        send_byte(8'(fr_len), stall);
        if (fr_len >= 1 && fr_len <= 16) begin
            for (int i = 0; i < fr_len; i++) begin
                if (i == start_at) pulse_start();
                send_byte(pay[i], stall);
            end
            send_byte(csum_b, stall);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic load_nominal();
        pay    = '{8'h04, 8'h85, 8'h46, 8'h2F, 8'h0C, 8'h0E};
        fr_len = 6;
        csum_b = 8'h18;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (hold0 !== 1'b1) $display("FAIL reset_hold: got %0b want 1", hold0); else n_pass++;
        n_checks++; if ({busy0, done0, err0, we0, rdy0} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {busy0, done0, err0, we0, rdy0}); else n_pass++;
        n_checks++; if (code0 !== 2'd0) $display("FAIL reset_code: got %0d want 0", code0); else n_pass++;
        n_checks++; if (addr0 !== 4'd0) $display("FAIL reset_addr0: got %0d want 0", addr0); else n_pass++;
        n_checks++; if (addr12 !== 4'd12) $display("FAIL reset_addr12: got %0d want 12", addr12); else n_pass++;
    endtask

    task automatic test_nominal();
        bit e_done; logic [1:0] e_code; int e_wr, b0;
        load_nominal();
        b0 = we_cnt0;
        send_frame(1'b0, -1);
        model_frame(e_done, e_code, e_wr);
        n_checks++; if (done0 !== e_done) $display("FAIL nominal_done: got %0b want %0b", done0, e_done); else n_pass++;
        n_checks++; if (hold0 !== !e_done) $display("FAIL nominal_hold: got %0b want %0b", hold0, !e_done); else n_pass++;
        n_checks++; if (we_cnt0 - b0 !== e_wr) $display("FAIL nominal_writes: got %0d want %0d", we_cnt0 - b0, e_wr); else n_pass++;
        for (int i = 0; i < 16; i++) if (wr0[i]) begin
            n_checks++; if (ram0[i] !== exp0[i]) $display("FAIL nominal_ram[%0d]: got %h want %h", i, ram0[i], exp0[i]); else n_pass++;
        end
    endtask

    task automatic test_bad_csum();
        bit e_done; logic [1:0] e_code; int e_wr, b0;
        load_nominal();
        csum_b = 8'h19;
        b0 = we_cnt0;
        send_frame(1'b0, -1);
        model_frame(e_done, e_code, e_wr);
        n_checks++; if (we_cnt0 - b0 !== e_wr) $display("FAIL badcsum_writes: got %0d want %0d", we_cnt0 - b0, e_wr); else n_pass++;
        n_checks++; if ({err0, done0, hold0} !== {!e_done, e_done, !e_done}) $display("FAIL badcsum_flags: got err/done/hold=%b", {err0, done0, hold0}); else n_pass++;
        n_checks++; if (code0 !== e_code) $display("FAIL badcsum_code: got %0d want %0d", code0, e_code); else n_pass++;
    endtask

    task automatic test_len_errors();
        bit e_done; logic [1:0] e_code; int e_wr, b0;
        int lens[2] = '{0, 17};
        foreach (lens[k]) begin
            pay.delete();
            fr_len = lens[k];
            csum_b = 8'h00;
            b0 = we_cnt0;
            send_frame(1'b0, -1);
            model_frame(e_done, e_code, e_wr);
            n_checks++; if (code0 !== e_code || err0 !== 1'b1) $display("FAIL len%0d_code: got err=%0b code=%0d want err=1 code=%0d", fr_len, err0, code0, e_code); else n_pass++;
            n_checks++; if (we_cnt0 - b0 !== e_wr) $display("FAIL len%0d_writes: got %0d want %0d", fr_len, we_cnt0 - b0, e_wr); else n_pass++;
        end
        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back(8'($urandom));
        fr_len = 16;
        csum_b = pay_sum();
        b0 = we_cnt0;
        send_frame(1'b0, -1);
        model_frame(e_done, e_code, e_wr);
        n_checks++; if (done0 !== e_done || done12 !== e_done) $display("FAIL len16_done: got %0b/%0b want %0b", done0, done12, e_done); else n_pass++;
        n_checks++; if (we_cnt0 - b0 !== e_wr) $display("FAIL len16_writes: got %0d want %0d", we_cnt0 - b0, e_wr); else n_pass++;
        n_checks++; if (ram0[15] !== pay[15]) $display("FAIL len16_last_addr15: got %h want %h", ram0[15], pay[15]); else n_pass++;
        n_checks++; if (ram12[11] !== exp12[11]) $display("FAIL len16_wrap12: got %h want %h", ram12[11], exp12[11]); else n_pass++;
    endtask

    task automatic test_wrap_stall();
        bit e_done; logic [1:0] e_code; int e_wr, b12;
        pay    = '{8'hA1, 8'hB2, 8'hC3};
        fr_len = 3;
        csum_b = pay_sum();
        b12 = we_cnt12;
        send_frame(1'b1, -1);
        model_frame(e_done, e_code, e_wr);
        n_checks++; if (done12 !== e_done) $display("FAIL wrap_done: got %0b want %0b", done12, e_done); else n_pass++;
        n_checks++; if (we_cnt12 - b12 !== e_wr) $display("FAIL wrap_writes: got %0d want %0d", we_cnt12 - b12, e_wr); else n_pass++;
        for (int i = 12; i < 15; i++) begin
            n_checks++; if (ram12[i] !== exp12[i]) $display("FAIL wrap_ram[%0d]: got %h want %h", i, ram12[i], exp12[i]); else n_pass++;
        end
    endtask

    task automatic test_abort_restart();
        bit e_done; logic [1:0] e_code; int e_wr, b0;
        load_nominal();
        b0 = we_cnt0;
        pulse_start();
        send_byte(8'd6, 1'b0);
        send_byte(pay[0], 1'b0);
        send_byte(pay[1], 1'b0);
        model_write(2);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pay[2];
        abort    = 1'b1;
        #1;
        n_checks++; if (rdy0 !== 1'b0) $display("FAIL abort_ready: got %0b want 0", rdy0); else n_pass++;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        n_checks++; if (err0 !== 1'b1 || code0 !== 2'd3) $display("FAIL abort_code: got err=%0b code=%0d want err=1 code=3", err0, code0); else n_pass++;
        n_checks++; if (we_cnt0 - b0 !== 2) $display("FAIL abort_writes: got %0d want 2", we_cnt0 - b0); else n_pass++;
        // abort outside a load has no effect
        @(negedge clk); abort = 1'b1; @(negedge clk); abort = 1'b0; #1;
        n_checks++; if (code0 !== 2'd3 || err0 !== 1'b1) $display("FAIL abort_idle_ignored: got err=%0b code=%0d want err=1 code=3", err0, code0); else n_pass++;
        b0 = we_cnt0;
        send_frame(1'b0, 2);
        model_frame(e_done, e_code, e_wr);
        n_checks++; if (done0 !== e_done || code0 !== e_code) $display("FAIL restart_done: got done=%0b code=%0d want done=%0b code=%0d", done0, code0, e_done, e_code); else n_pass++;
        n_checks++; if (we_cnt0 - b0 !== e_wr) $display("FAIL restart_writes: got %0d want %0d", we_cnt0 - b0, e_wr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit e_done; logic [1:0] e_code; int e_wr;
        load_nominal();
        pulse_start();
        send_byte(8'd6, 1'b0);
        send_byte(pay[0], 1'b0);
        send_byte(pay[1], 1'b0);
        model_write(2);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        #1;
        n_checks++; if ({busy0, done0, err0, rdy0, hold0} !== 5'b00001) $display("FAIL resetmid_state: got busy/done/err/rdy/hold=%b want 00001", {busy0, done0, err0, rdy0, hold0}); else n_pass++;
        n_checks++; if (ram0[1] !== exp0[1]) $display("FAIL resetmid_ram_kept: got %h want %h", ram0[1], exp0[1]); else n_pass++;
        send_frame(1'b0, -1);
        model_frame(e_done, e_code, e_wr);
        n_checks++; if (done0 !== e_done || hold0 !== !e_done) $display("FAIL resetmid_reload: got done=%0b hold=%0b want done=%0b", done0, hold0, e_done); else n_pass++;
    endtask

    task automatic test_random();
        bit e_done; logic [1:0] e_code; int e_wr, b0, b12;
        for (int f = 0; f < 30; f++) begin
            pay.delete();
            case ($urandom_range(0, 5))
                0:       fr_len = 0;
                1:       fr_len = int'($urandom_range(17, 255));
                default: fr_len = int'($urandom_range(1, 16));
            endcase
            if (fr_len >= 1 && fr_len <= 16)
                for (int i = 0; i < fr_len; i++) pay.push_back(8'($urandom));
            csum_b = pay_sum();
            if ($urandom_range(0, 3) == 0) csum_b = csum_b ^ 8'(1 << $urandom_range(0, 7));
            b0  = we_cnt0;
            b12 = we_cnt12;
            send_frame(1'($urandom_range(0, 1)), -1);
            model_frame(e_done, e_code, e_wr);
            n_checks++; if ({done0, err0, hold0, code0} !== {e_done, !e_done, !e_done, e_code}) $display("FAIL rand%0d_outcome0: got done=%0b err=%0b code=%0d want done=%0b code=%0d", f, done0, err0, code0, e_done, e_code); else n_pass++;
            n_checks++; if ({done12, code12} !== {e_done, e_code}) $display("FAIL rand%0d_outcome12: got done=%0b code=%0d want done=%0b code=%0d", f, done12, code12, e_done, e_code); else n_pass++;
            n_checks++; if (we_cnt0 - b0 !== e_wr || we_cnt12 - b12 !== e_wr) $display("FAIL rand%0d_writes: got %0d/%0d want %0d", f, we_cnt0 - b0, we_cnt12 - b12, e_wr); else n_pass++;
            for (int i = 0; i < 16; i++) begin
                if (wr0[i]) begin
                    n_checks++; if (ram0[i] !== exp0[i]) $display("FAIL rand%0d_ram0[%0d]: got %h want %h", f, i, ram0[i], exp0[i]); else n_pass++;
                end
                if (wr12[i]) begin
                    n_checks++; if (ram12[i] !== exp12[i]) $display("FAIL rand%0d_ram12[%0d]: got %h want %h", f, i, ram12[i], exp12[i]); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            wr0[i]  = 1'b0;
            wr12[i] = 1'b0;
        end
        test_reset();
        test_nominal();
        test_bad_csum();
        test_len_errors();
        test_wrap_stall();
        test_abort_restart();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
